// File: rtl/jpeg2bmp_idct_acc8_if.sv
// Product-in / result-out handshake bundle for the IDCT accumulator.
// master = upstream/downstream side, slave = the accumulator itself.
interface jpeg2bmp_idct_acc8_if #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 16
);
  logic                         in_valid;
  logic signed [DIN_WIDTH-1:0]  din;
  logic                         in_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         sat_flag;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout, sat_flag
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout, sat_flag
  );
endinterface

// File: rtl/jpeg2bmp_idct_acc8.sv
// Sums ACC_LEN signed products, rounds half-up, descales by SHIFT and emits one result per group.
// Define JPEG2BMP_IDCT_ACC_SAT_EN to clamp out-of-range results and raise a sticky sat_flag.
module jpeg2bmp_idct_acc8 #(
  parameter int DIN_WIDTH  = 32,
  parameter int ACC_LEN    = 8,
  parameter int SHIFT      = 11,
  parameter int DOUT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ce,
  jpeg2bmp_idct_acc8_if.slave        bus
);
  localparam int CNT_W = $clog2(ACC_LEN);
  localparam int ACC_W = DIN_WIDTH + CNT_W + 1;

  localparam logic ACCUM = 1'b0;
  localparam logic HOLD  = 1'b1;

  localparam logic [CNT_W-1:0]        LAST  = CNT_W'(ACC_LEN - 1);
  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(64'd1 << (SHIFT - 1));

  logic                         state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                         out_valid_q, out_valid_d;

  logic signed [ACC_W-1:0]      din_ext;
  logic signed [ACC_W-1:0]      sum;
  logic signed [ACC_W-1:0]      shifted;
  logic signed [DOUT_WIDTH-1:0] res;
  logic                         in_ready;
  logic                         accept;
  logic                         emit;
  logic                         last_beat;

  assign in_ready  = ce && ((state_q == ACCUM) || bus.out_ready);
  assign accept    = ce && bus.in_valid && in_ready;
  assign emit      = ce && out_valid_q && bus.out_ready;
  assign last_beat = (cnt_q == LAST);

  assign din_ext = {{(ACC_W - DIN_WIDTH){bus.din[DIN_WIDTH-1]}}, bus.din};
  assign sum     = acc_q + din_ext + ROUND;
  assign shifted = sum >>> SHIFT;

`ifdef JPEG2BMP_IDCT_ACC_SAT_EN
  localparam logic signed [DOUT_WIDTH-1:0] DOUT_MAX = {1'b0, {(DOUT_WIDTH - 1){1'b1}}};
  localparam logic signed [DOUT_WIDTH-1:0] DOUT_MIN = {1'b1, {(DOUT_WIDTH - 1){1'b0}}};

  logic ovf;
  logic sat_q, sat_d;

  // Fits only if every bit above the output sign bit repeats the sign.
  assign ovf = (shifted[ACC_W-1:DOUT_WIDTH-1] != {(ACC_W - DOUT_WIDTH + 1){shifted[ACC_W-1]}});
  assign res = ovf ? (shifted[ACC_W-1] ? DOUT_MIN : DOUT_MAX) : shifted[DOUT_WIDTH-1:0];

  always_comb begin
    sat_d = sat_q;
    if (accept && last_beat && ovf) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign bus.sat_flag = sat_q;
`else
  logic unused_hi;

  assign unused_hi    = ^shifted[ACC_W-1:DOUT_WIDTH];
  assign res          = shifted[DOUT_WIDTH-1:0];
  assign bus.sat_flag = 1'b0;
`endif

  // Emit and accept are independent, so a HOLD cycle can hand off a result and start the next sum.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    if (emit) begin
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end
    if (accept) begin
      if (last_beat) begin
        acc_d       = '0;
        cnt_d       = '0;
        dout_d      = res;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end else begin
        acc_d = acc_q + din_ext;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      acc_q       <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
endmodule

// File: tb/tb_jpeg2bmp_idct_acc8.sv
// Scoreboard bench for jpeg2bmp_idct_acc8: group sums modelled on acceptance, compared on emit.
module tb_jpeg2bmp_idct_acc8;
  localparam int DW = 32;
  localparam int AL = 8;
  localparam int SH = 11;
  localparam int OW = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ce = 1'b0;

  always #5 clk = ~clk;

  jpeg2bmp_idct_acc8_if #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW)) bus ();

  jpeg2bmp_idct_acc8 #(
    .DIN_WIDTH (DW),
    .ACC_LEN   (AL),
    .SHIFT     (SH),
    .DOUT_WIDTH(OW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .bus  (bus)
  );

  int     n_checks = 0;
  int     n_fail = 0;
  int     n_out = 0;
  int     stall_cnt = 0;
  int     gcnt = 0;
  longint gsum = 0;
  bit     sat_exp = 1'b0;
  longint q_exp[$];
  longint emit_t[$];

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference descale: round half up, arithmetic shift, then wrap or clamp to the output width.
  task automatic model_push(input longint s);
    longint r;
    logic [63:0] rv;
    logic signed [OW-1:0] t;
    r  = (s + (64'sd1 <<< (SH - 1))) >>> SH;
    rv = r;
`ifdef JPEG2BMP_IDCT_ACC_SAT_EN
    if (r > 32767) begin
      r = 32767;
      sat_exp = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      sat_exp = 1'b1;
    end
    q_exp.push_back(r);
`else
    t = rv[OW-1:0];
    q_exp.push_back(longint'(t));
`endif
  endtask

  always @(negedge clk) begin
    if (reset && ce) begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        emit_t.push_back($time);
        if (q_exp.size() == 0) check("unexpected_out", 1, 0);
        else check("dout", longint'(bus.dout), q_exp.pop_front());
        check("sat_flag", longint'(bus.sat_flag), longint'(sat_exp));
      end
      if (bus.in_valid && bus.in_ready) begin
        gsum += longint'(bus.din);
        gcnt++;
        if (gcnt == AL) begin
          model_push(gsum);
          gsum = 0;
          gcnt = 0;
        end
      end
    end
  end

  task automatic send(input int d);
    int t;
    bus.in_valid = 1'b1;
    bus.din      = d;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      t++;
      stall_cnt++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_group(input int d);
    for (int i = 0; i < AL; i++) send(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    longint exp_p;
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.out_ready = 1'b1;
    ce            = 1'b1;
    #3;
    check("rst_dout", longint'(bus.dout), 0);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_sat_flag", longint'(bus.sat_flag), 0);
    #9 reset = 1'b1;
    idle(1);
    check("rst_in_ready", longint'(bus.in_ready), 1);

    // Single group, one-cycle latency and one-cycle valid pulse.
    send_group(256);
    check("g256_valid", longint'(bus.out_valid), 1);
    check("g256_dout", longint'(bus.dout), 1);
    idle(1);
    check("g256_valid_drop", longint'(bus.out_valid), 0);

    send_group(1024);
    send_group(-1024);
    idle(1);
    check("neg_dout", longint'(bus.dout), -4);

    send_group(32'h7FFF_FFFF);
`ifdef JPEG2BMP_IDCT_ACC_SAT_EN
    check("big_dout", longint'(bus.dout), 32767);
    check("big_sat", longint'(bus.sat_flag), 1);
`else
    check("big_dout", longint'(bus.dout), 0);
    check("big_sat", longint'(bus.sat_flag), 0);
`endif
    idle(2);

    // Back-to-back groups with no input bubble.
    stall_cnt = 0;
    emit_t.delete();
    send_group(256);
    send_group(256);
    idle(2);
    check("b2b_stalls", stall_cnt, 0);
    check("b2b_results", emit_t.size(), 2);
    if (emit_t.size() == 2) check("b2b_gap", emit_t[1] - emit_t[0], 80);

    // Result held under backpressure and with ce low; stray input ignored.
    bus.out_ready = 1'b0;
    for (int i = 0; i < AL; i++) send(int'($urandom_range(0, 200000)) - 100000);
    check("stall_valid", longint'(bus.out_valid), 1);
    exp_p = (q_exp.size() > 0) ? q_exp[0] : 64'sd99999;
    bus.in_valid = 1'b1;
    bus.din      = 12345;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold_valid", longint'(bus.out_valid), 1);
      check("stall_hold_dout", longint'(bus.dout), exp_p);
      check("stall_in_ready", longint'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    ce = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ce0_valid", longint'(bus.out_valid), 1);
      check("ce0_dout", longint'(bus.dout), exp_p);
      check("ce0_in_ready", longint'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    ce = 1'b1;
    idle(1);
    check("single_xfer", longint'(bus.out_valid), 0);
    idle(1);
    check("single_xfer_hold", longint'(bus.out_valid), 0);

    // ce low mid-group freezes the partial sum.
    for (int i = 0; i < 3; i++) send(512);
    ce = 1'b0;
    bus.in_valid = 1'b1;
    bus.din      = 999;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ce0_mid_in_ready", longint'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    ce = 1'b1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) send(512);
    check("ce_group_dout", longint'(bus.dout), 2);
    idle(2);

    // Reset mid-group discards the partial sum.
    for (int i = 0; i < 5; i++) send(256);
    #3 reset = 1'b0;
    gsum = 0;
    gcnt = 0;
    sat_exp = 1'b0;
    q_exp.delete();
    #2;
    check("mid_rst_dout", longint'(bus.dout), 0);
    check("mid_rst_valid", longint'(bus.out_valid), 0);
    check("mid_rst_sat", longint'(bus.sat_flag), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    idle(1);
    send_group(256);
    check("post_rst_dout", longint'(bus.dout), 1);
    idle(1);

    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < AL; i++) send(int'($urandom_range(0, 4000000)) - 2000000);
    end
    idle(3);

    check("queue_empty", q_exp.size(), 0);
    check("result_count", n_out, 12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/jpeg2bmp_idct_acc8.md
JPEG2BMP_IDCT_ACC8 -- requirements
Module: jpeg2bmp_idct_acc8

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 32, signed product width from upstream multiplier.
REQ-002 SHALL have parameter ACC_LEN, default 8, products summed per output (power of two, 2..16).
REQ-003 SHALL have parameter SHIFT, default 11, descale right-shift applied to sum (1..20).
REQ-004 SHALL have parameter DOUT_WIDTH, default 16, signed output width.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port ce  in  1  clock enable; when low, all state frozen.
REQ-008 SHALL have port in_valid  in  1  din carries a valid product.
REQ-009 SHALL have port din  in  DIN_WIDTH  signed product from multiplier stage.
REQ-010 SHALL have port in_ready  out  1  block accepts din this cycle.
REQ-011 SHALL have port out_valid  out  1  dout holds a valid result.
REQ-012 SHALL have port out_ready  in  1  downstream accepts dout.
REQ-013 SHALL have port dout  out  DOUT_WIDTH  signed descaled sum.
REQ-014 SHALL have port sat_flag  out  1  sticky: some result saturated.

Function
REQ-015 SHALL accept a beat when ce && in_valid && in_ready; SHALL emit a beat when ce && out_valid && out_ready.
REQ-016 SHALL use FSM states ACCUM and HOLD; reset state ACCUM.
REQ-017 ACCUM: in_ready=ce; each accepted beat adds sign-extended din to accumulator (width DIN_WIDTH+log2(ACC_LEN)+1, no internal overflow) and increments beat counter.
REQ-018 On the ACC_LEN-th accepted beat: result = (acc + din + 2^(SHIFT-1)) arithmetic-shift-right SHIFT (round half up toward +inf); register into dout; out_valid=1 next cycle; accumulator and counter clear; go HOLD.
REQ-019 HOLD: in_ready = ce && out_ready; beat accepted while out_ready=1 starts a new sum (counter=1, acc=din) in same cycle as output transfer, enabling zero-bubble back-to-back groups.
REQ-020 HOLD with output transfer: go ACCUM unless that same cycle completes a group (ACC_LEN=... not reachable for ACC_LEN>=2, so always ACCUM); out_valid drops unless new result loaded.
REQ-021 dout and out_valid SHALL remain stable while out_valid && !out_ready (including while ce=0).
REQ-022 Latency: dout valid 1 cycle after final accepted beat of a group.
REQ-023 ce=0: no accept, no emit, no counter/accumulator/FSM change; in_ready=0.
REQ-024 in_valid while in_ready=0 SHALL be ignored (upstream holds data).

Reset
REQ-025 reset low SHALL asynchronously force: state ACCUM, counter 0, accumulator 0, dout 0, out_valid 0, sat_flag 0; release synchronised to clk by integrator; partial group discarded.

Configuration
REQ-026 Macro JPEG2BMP_IDCT_ACC_SAT_EN: when defined, result outside DOUT_WIDTH signed range clamps to max/min and sets sat_flag (cleared only by reset); when undefined, result truncated to low DOUT_WIDTH bits (two's-complement wrap) and sat_flag tied 0.

Verification (defaults)
REQ-027 Eight beats din=256, out_ready=1 -> one cycle later dout=1, out_valid=1 for one cycle.
REQ-028 Eight beats din=1024 -> dout=4; eight beats din=-1024 -> dout=-4.
REQ-029 Eight beats din=0x7FFFFFFF -> with macro: dout=32767, sat_flag=1; without: dout=0, sat_flag=0.
REQ-030 16 back-to-back beats din=256, out_ready=1 -> in_ready never drops, two results of 1 eight cycles apart.
REQ-031 Result pending, out_ready=0 for 5 cycles -> dout/out_valid stable, in_ready=0; out_ready=1 -> single transfer.
REQ-032 Reset asserted after 5 of 8 beats -> all outputs 0; next 8 beats din=256 -> dout=1 (no residue).
